// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the memory handshake slice. Holds the
//               responder state encoding, the rw access-type codes and the
//               default address/data widths used by the store and load FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 16;

  // Binary 2-bit encoding; code 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_WAIT = 2'b01,
    MEM_DONE = 2'b10
  } mem_state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Single-port word storage with synchronous write and a
//               registered synchronous read. Nothing happens unless the
//               controller pulses do_access for one cycle.
// Ports       : clk       - system clock
//               rst       - asynchronous reset, active-low (clears rdata only)
//               do_access - one-cycle access strobe from the controller
//               we        - 1 = write wdata to addr, 0 = read addr into rdata
//               addr      - word address
//               wdata     - write data
//               rdata     - registered read data, holds between reads
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              do_access,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Storage deliberately has no reset so it maps onto plain RAM.
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (do_access && we) begin
      r_mem[addr] <= wdata;
    end
  end

  // Read register is cleared by reset and otherwise only changes on a read,
  // so writes and aborted requests leave the last read value visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (do_access && !we) begin
      rdata <= r_mem[addr];
    end
  end

endmodule : mem_array
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : memory_responder
// Description : Memory-side end of the en/rw/mfc 4-phase handshake. Accepts
//               a request, performs the access LATENCY edges later, raises
//               mfc and holds it until the initiator drops en.
// Ports       : clk   - system clock, rising edge
//               rst   - asynchronous reset, active-low
//               en    - level-held request strobe
//               rw    - 0 = write (store), 1 = read (load)
//               addr  - address from MAR
//               wdata - write data from MDR
//               rdata - read data to MDR, valid while mfc=1 after a read
//               mfc   - memory-function-complete
//               busy  - high from request accept until return to IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module memory_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mfc,
  output logic              busy
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("memory_responder: LATENCY must be in 1..15");
    end
  endgenerate

  // Counter preload: WAIT spends LATENCY edges, the last of which enters DONE.
  localparam logic [3:0] C_CNT_LOAD = 4'(LATENCY - 1);

  mem_state_t        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rw;
  logic              r_mfc;
  logic              r_busy;

  logic              w_do_access;
  logic              w_we;

  // The access fires on exactly the edge that moves WAIT -> DONE, so the
  // array result lands together with the mfc rise.
  assign w_do_access = (r_state == MEM_WAIT) && en && (r_cnt == 4'd0);
  assign w_we        = (r_rw == RW_WRITE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MEM_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rw    <= RW_WRITE;
      r_mfc   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (en) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_rw    <= rw;
            r_cnt   <= C_CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (!en) begin
            // Initiator gave up: no access, mfc never rises.
            r_busy  <= 1'b0;
            r_state <= MEM_IDLE;
          end else if (r_cnt == 4'd0) begin
            r_mfc   <= 1'b1;
            r_state <= MEM_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        MEM_DONE: begin
          // No timeout; only en falling ends the handshake. Staying here
          // while en is held prevents a second access without en toggling.
          if (!en) begin
            r_mfc   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= MEM_IDLE;
          end
        end
        default: begin
          r_mfc   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= MEM_IDLE;
        end
      endcase
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk       (clk),
    .rst       (rst),
    .do_access (w_do_access),
    .we        (w_we),
    .addr      (r_addr),
    .wdata     (r_wdata),
    .rdata     (rdata)
  );

  assign mfc  = r_mfc;
  assign busy = r_busy;

endmodule : memory_responder
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_responder
// Description : Self-checking bench for memory_responder. Three instances
//               with LATENCY 3, 1 and 7 are exercised with a directed vector
//               table, hand-written abort/reset sequences and a randomized
//               phase checked against a simple memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_responder;

  localparam int NDUT = 3;

  logic        clk;
  logic        rst;
  logic        en    [NDUT];
  logic        rw    [NDUT];
  logic [7:0]  addr  [NDUT];
  logic [15:0] wdata [NDUT];
  logic [15:0] rdata [NDUT];
  logic        mfc   [NDUT];
  logic        busy  [NDUT];

  int n_vec;
  int n_err;

  // Reference model: last value written per address, and whether known.
  logic [15:0] mem_m [NDUT][256];
  bit          vld_m [NDUT][256];

  function automatic int lat_of(input int d);
    return (d == 0) ? 3 : ((d == 1) ? 1 : 7);
  endfunction

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      memory_responder #(
        .ADDR_W  (8),
        .DATA_W  (16),
        .LATENCY ((gi == 0) ? 3 : ((gi == 1) ? 1 : 7))
      ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en[gi]),
        .rw    (rw[gi]),
        .addr  (addr[gi]),
        .wdata (wdata[gi]),
        .rdata (rdata[gi]),
        .mfc   (mfc[gi]),
        .busy  (busy[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full 4-phase handshake on instance d. Inputs are scrambled after
  // accept to confirm only latched values are used.
  task automatic op(input int d, input logic r, input logic [7:0] a,
                    input logic [15:0] wd, input int hold,
                    input bit use_exp, input logic [15:0] exp);
    int          n;
    logic [15:0] saved;
    logic [15:0] want;
    en[d] = 1'b1; rw[d] = r; addr[d] = a; wdata[d] = wd;
    tick();
    chk("accept_busy", {31'd0, busy[d]}, 32'd1);
    chk("accept_mfc", {31'd0, mfc[d]}, 32'd0);
    rw[d] = ~r; addr[d] = 8'($urandom); wdata[d] = 16'($urandom);
    n = 0;
    while (mfc[d] !== 1'b1 && n < 40) begin
      tick();
      n++;
      chk("wait_busy", {31'd0, busy[d]}, 32'd1);
    end
    chk("mfc_latency", n, lat_of(d));
    saved = rdata[d];
    if (r == 1'b1) begin
      want = use_exp ? exp : mem_m[d][a];
      if (use_exp || vld_m[d][a]) chk("rdata", {16'd0, rdata[d]}, {16'd0, want});
    end
    for (int k = 0; k < hold; k++) begin
      addr[d] = 8'($urandom); wdata[d] = 16'($urandom); rw[d] = 1'($urandom);
      tick();
      chk("hold_mfc", {31'd0, mfc[d]}, 32'd1);
      chk("hold_rdata", {16'd0, rdata[d]}, {16'd0, saved});
    end
    en[d] = 1'b0;
    tick();
    chk("release_mfc", {31'd0, mfc[d]}, 32'd0);
    chk("release_busy", {31'd0, busy[d]}, 32'd0);
    chk("release_rdata", {16'd0, rdata[d]}, {16'd0, saved});
    if (r == 1'b0) begin
      mem_m[d][a] = wd;
      vld_m[d][a] = 1'b1;
    end
  endtask

  typedef struct {
    int          d;
    logic        r;
    logic [7:0]  a;
    logic [15:0] wd;
    int          hold;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      en[i] = 1'b0; rw[i] = 1'b0; addr[i] = 8'd0; wdata[i] = 16'd0;
      for (int j = 0; j < 256; j++) begin
        mem_m[i][j] = 16'd0;
        vld_m[i][j] = 1'b0;
      end
    end

    //            d  rw    addr   wdata     hold exp
    tbl[0]  = '{0, 1'b0, 8'h05, 16'hBEEF, 0,  16'h0000};
    tbl[1]  = '{0, 1'b1, 8'h05, 16'h0000, 2,  16'hBEEF};
    tbl[2]  = '{0, 1'b0, 8'h10, 16'h5A5A, 0,  16'h0000};
    tbl[3]  = '{0, 1'b0, 8'h00, 16'h1111, 0,  16'h0000};
    tbl[4]  = '{0, 1'b0, 8'h01, 16'h2222, 0,  16'h0000};
    tbl[5]  = '{0, 1'b0, 8'h02, 16'h3333, 0,  16'h0000};
    tbl[6]  = '{0, 1'b0, 8'h03, 16'h4444, 0,  16'h0000};
    tbl[7]  = '{0, 1'b1, 8'h00, 16'h0000, 0,  16'h1111};
    tbl[8]  = '{0, 1'b1, 8'h01, 16'h0000, 0,  16'h2222};
    tbl[9]  = '{0, 1'b1, 8'h02, 16'h0000, 0,  16'h3333};
    tbl[10] = '{0, 1'b1, 8'h03, 16'h0000, 0,  16'h4444};
    tbl[11] = '{1, 1'b0, 8'h40, 16'hC0DE, 0,  16'h0000};
    tbl[12] = '{1, 1'b1, 8'h40, 16'h0000, 1,  16'hC0DE};
    tbl[13] = '{2, 1'b0, 8'h41, 16'hF00D, 0,  16'h0000};
    tbl[14] = '{2, 1'b1, 8'h41, 16'h0000, 1,  16'hF00D};
    tbl[15] = '{0, 1'b0, 8'h22, 16'h0A77, 10, 16'h0000};
    tbl[16] = '{0, 1'b1, 8'h22, 16'h0000, 0,  16'h0A77};

    // Reset state
    tick();
    tick();
    for (int i = 0; i < NDUT; i++) begin
      chk("reset_mfc", {31'd0, mfc[i]}, 32'd0);
      chk("reset_busy", {31'd0, busy[i]}, 32'd0);
      chk("reset_rdata", {16'd0, rdata[i]}, 32'd0);
    end
    rst = 1'b1;
    tick();

    // Directed table, issued back-to-back
    for (int i = 0; i < 17; i++) begin
      op(tbl[i].d, tbl[i].r, tbl[i].a, tbl[i].wd, tbl[i].hold, 1'b1, tbl[i].exp);
    end

    // Abort: en high for two edges then dropped during WAIT
    tick();
    en[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'h10; wdata[0] = 16'h1234;
    tick();
    chk("abort_busy_accept", {31'd0, busy[0]}, 32'd1);
    tick();
    chk("abort_mfc_wait", {31'd0, mfc[0]}, 32'd0);
    en[0] = 1'b0;
    tick();
    chk("abort_busy", {31'd0, busy[0]}, 32'd0);
    chk("abort_mfc", {31'd0, mfc[0]}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_mfc_quiet", {31'd0, mfc[0]}, 32'd0);
    end
    op(0, 1'b1, 8'h10, 16'h0000, 0, 1'b1, 16'h5A5A);

    // Asynchronous reset in the middle of a write to 0x05
    en[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'h05; wdata[0] = 16'hDEAD;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_mfc", {31'd0, mfc[0]}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_mid_rdata", {16'd0, rdata[0]}, 32'd0);
    en[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_idle_busy", {31'd0, busy[0]}, 32'd0);
      chk("rst_idle_mfc", {31'd0, mfc[0]}, 32'd0);
    end
    op(0, 1'b1, 8'h05, 16'h0000, 0, 1'b1, 16'hBEEF);

    // Randomized handshakes against the model
    for (int it = 0; it < 60; it++) begin
      int          d;
      logic [7:0]  a;
      logic        r;
      d = $urandom_range(0, NDUT - 1);
      a = 8'($urandom_range(0, 15));
      r = 1'($urandom_range(0, 1));
      if (!vld_m[d][a]) r = 1'b0;
      op(d, r, a, 16'($urandom), $urandom_range(0, 3), 1'b0, 16'h0000);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule : tb_memory_responder
`default_nettype wire
